// File: rtl/iir_biquad_filter.sv
// Second-order Direct Form I IIR filter with double-buffered coefficients,
// saturating output with sticky flag, history flush and bypass.
module iir_biquad_filter #(
  parameter int unsigned NB   = 10,
  parameter int unsigned NC   = 10,
  parameter int unsigned FRAC = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic signed [NB-1:0] DIN,
  input  logic                 VIN,
  input  logic                 COEF_WE,
  input  logic [2:0]           COEF_ADDR,
  input  logic signed [NC-1:0] COEF_DATA,
  input  logic                 COEF_COMMIT,
  input  logic                 FLUSH,
  input  logic                 BYPASS,
  input  logic                 CLR_SAT,
  output logic signed [NB-1:0] DOUT,
  output logic                 VOUT,
  output logic                 SAT
);

  localparam int unsigned ACC_W = NB + NC + 3;
  localparam int unsigned NCOEF = 5;
  localparam int unsigned IDX_B0 = 0;
  localparam int unsigned IDX_B1 = 1;
  localparam int unsigned IDX_B2 = 2;
  localparam int unsigned IDX_A1 = 3;
  localparam int unsigned IDX_A2 = 4;

  localparam logic signed [NB-1:0]    OUT_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0]    OUT_MIN = {1'b1, {(NB-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(OUT_MIN);

  // Coefficient banks: shadow is written by the host, active feeds the MACs
  logic signed [NC-1:0] shd_q [NCOEF];
  logic signed [NC-1:0] shd_d [NCOEF];
  logic signed [NC-1:0] act_q [NCOEF];
  logic signed [NC-1:0] act_d [NCOEF];

  logic signed [NB-1:0] x1_q, x1_d, x2_q, x2_d;
  logic signed [NB-1:0] y1_q, y1_d, y2_q, y2_d;
  logic signed [NB-1:0] dout_q, dout_d;
  logic                 vout_q, vout_d;
  logic                 sat_q, sat_d;

  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] shf_c;
  logic signed [NB-1:0]    y_c;
  logic                    clip_c;
  logic                    filt_c;

  // Operands widened to the accumulator width so no product or sum can wrap
  function automatic logic signed [ACC_W-1:0] mul(
    input logic signed [NC-1:0] c,
    input logic signed [NB-1:0] s
  );
    logic signed [ACC_W-1:0] ce;
    logic signed [ACC_W-1:0] se;
    ce  = ACC_W'(c);
    se  = ACC_W'(s);
    mul = ce * se;
  endfunction

  // Filter datapath: MAC, arithmetic shift (floor), clamp
  always_comb begin
    acc_c = mul(act_q[IDX_B0], DIN)
          + mul(act_q[IDX_B1], x1_q)
          + mul(act_q[IDX_B2], x2_q)
          - mul(act_q[IDX_A1], y1_q)
          - mul(act_q[IDX_A2], y2_q);
    shf_c  = acc_c >>> FRAC;
    clip_c = 1'b0;
    y_c    = shf_c[NB-1:0];
    if (shf_c > ACC_MAX) begin
      y_c    = OUT_MAX;
      clip_c = 1'b1;
    end else if (shf_c < ACC_MIN) begin
      y_c    = OUT_MIN;
      clip_c = 1'b1;
    end
  end

  assign filt_c = VIN && !BYPASS;

  // Next-state: coefficients, history, output registers, sticky flag
  always_comb begin
    for (int i = 0; i < NCOEF; i++) begin
      shd_d[i] = shd_q[i];
      act_d[i] = act_q[i];
    end
    x1_d   = x1_q;
    x2_d   = x2_q;
    y1_d   = y1_q;
    y2_d   = y2_q;
    dout_d = dout_q;
    vout_d = 1'b0;
    sat_d  = sat_q;

    // Commit reads the registered shadow, so a same-cycle write is not copied
    for (int i = 0; i < NCOEF; i++) begin
      if (COEF_COMMIT) act_d[i] = shd_q[i];
      if (COEF_WE && (COEF_ADDR == 3'(i))) shd_d[i] = COEF_DATA;
    end

    if (VIN) begin
      vout_d = 1'b1;
      dout_d = BYPASS ? DIN : y_c;
    end

    if (filt_c) begin
      x2_d = x1_q;
      x1_d = DIN;
      y2_d = y1_q;
      y1_d = y_c;
    end

    if (FLUSH) begin
      x1_d = '0;
      x2_d = '0;
      y1_d = '0;
      y2_d = '0;
    end

    if (CLR_SAT) sat_d = 1'b0;
    if (filt_c && clip_c) sat_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCOEF; i++) begin
        shd_q[i] <= '0;
        act_q[i] <= '0;
      end
      x1_q   <= '0;
      x2_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCOEF; i++) begin
        shd_q[i] <= shd_d[i];
        act_q[i] <= act_d[i];
      end
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      y1_q   <= y1_d;
      y2_q   <= y2_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      sat_q  <= sat_d;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;
  assign SAT  = sat_q;

endmodule

// File: tb/tb_iir_biquad_filter.sv
// Directed, table-driven bench for iir_biquad_filter (NB=10, NC=10, FRAC=9).
module tb_iir_biquad_filter;

  logic                clk;
  logic                rst;
  logic signed [9:0]   din;
  logic                vin;
  logic                coef_we;
  logic [2:0]          coef_addr;
  logic signed [9:0]   coef_data;
  logic                coef_commit;
  logic                flush;
  logic                bypass;
  logic                clr_sat;
  logic signed [9:0]   dout;
  logic                vout;
  logic                sat;

  int checks;
  int errors;

  typedef struct {
    logic              we;
    logic [2:0]        addr;
    logic signed [9:0] data;
    logic              commit;
    logic              vin;
    logic signed [9:0] din;
    logic              flush;
    logic              bypass;
    logic              clr;
    logic              e_vout;
    logic signed [9:0] e_dout;
    logic              e_sat;
  } vec_t;

  vec_t tbl[$];

  iir_biquad_filter #(.NB(10), .NC(10), .FRAC(9)) dut (
    .CLK(clk), .RST(rst), .DIN(din), .VIN(vin),
    .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
    .COEF_COMMIT(coef_commit), .FLUSH(flush), .BYPASS(bypass),
    .CLR_SAT(clr_sat), .DOUT(dout), .VOUT(vout), .SAT(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int we, int addr, int data, int commit, int v,
                              int d, int fl, int bp, int clr,
                              int ev, int ed, int es);
    vec_t r;
    r.we = 1'(we); r.addr = 3'(addr); r.data = 10'(data);
    r.commit = 1'(commit); r.vin = 1'(v); r.din = 10'(d);
    r.flush = 1'(fl); r.bypass = 1'(bp); r.clr = 1'(clr);
    r.e_vout = 1'(ev); r.e_dout = 10'(ed); r.e_sat = 1'(es);
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t r);
    cmp({tag, " VOUT"}, int'(vout), int'(r.e_vout));
    cmp({tag, " DOUT"}, int'(dout), int'(r.e_dout));
    cmp({tag, " SAT"},  int'(sat),  int'(r.e_sat));
  endtask

  // Drive one row at the falling edge, check registered outputs after the rise
  task automatic apply(input string tag, input vec_t r);
    @(negedge clk);
    coef_we = r.we; coef_addr = r.addr; coef_data = r.data;
    coef_commit = r.commit; vin = r.vin; din = r.din;
    flush = r.flush; bypass = r.bypass; clr_sat = r.clr;
    @(posedge clk);
    #1;
    check_all(tag, r);
  endtask

  initial begin
    vec_t r;
    checks = 0; errors = 0;
    rst = 1'b1; din = '0; vin = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; coef_commit = 1'b0; flush = 1'b0; bypass = 1'b0;
    clr_sat = 1'b0;

    //          we a  data  cm v  din  fl bp cl  ev  edout  es
    tbl.push_back(mk(1, 0,  215, 0, 0,    0, 0, 0, 0, 0,    0, 0)); // 0 shadow b0
    tbl.push_back(mk(0, 0,    0, 0, 1,  100, 0, 0, 0, 1,    0, 0)); // 1 no commit yet
    tbl.push_back(mk(0, 0,    0, 1, 0,    0, 0, 0, 0, 0,    0, 0)); // 2 commit
    tbl.push_back(mk(0, 0,    0, 0, 1,  100, 0, 0, 0, 1,   41, 0)); // 3 pure gain
    tbl.push_back(mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 0,   41, 0)); // 4 gap holds
    tbl.push_back(mk(1, 0,  511, 0, 0,    0, 0, 0, 0, 0,   41, 0)); // 5 shadow only
    tbl.push_back(mk(0, 0,    0, 0, 1,  100, 0, 0, 0, 1,   41, 0)); // 6
    tbl.push_back(mk(0, 0,    0, 1, 1,  100, 0, 0, 0, 1,   41, 0)); // 7 commit same cycle
    tbl.push_back(mk(0, 0,    0, 0, 1,  100, 0, 0, 0, 1,   99, 0)); // 8 new b0
    tbl.push_back(mk(1, 1,  215, 0, 0,    0, 0, 0, 0, 0,   99, 0)); // 9
    tbl.push_back(mk(1, 3,  -82, 0, 0,    0, 0, 0, 0, 0,   99, 0)); // 10
    tbl.push_back(mk(1, 0,  215, 1, 0,    0, 1, 0, 0, 0,   99, 0)); // 11 WE+COMMIT
    tbl.push_back(mk(0, 0,    0, 0, 1,  100, 0, 0, 0, 1,   99, 0)); // 12 b0 still 511
    tbl.push_back(mk(0, 0,    0, 1, 0,    0, 1, 0, 0, 0,   99, 0)); // 13 commit b0=215
    tbl.push_back(mk(0, 0,    0, 0, 1,  256, 0, 0, 0, 1,  107, 0)); // 14 impulse
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,  124, 0)); // 15
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,   19, 0)); // 16
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,    3, 0)); // 17
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,    0, 0)); // 18
    tbl.push_back(mk(0, 0,    0, 0, 1,  256, 0, 0, 0, 1,  107, 0)); // 19
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 1, 0, 0, 1,  124, 0)); // 20 flush w/ sample
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,    0, 0)); // 21
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,    0, 0)); // 22
    tbl.push_back(mk(0, 0,    0, 0, 1,  256, 0, 0, 0, 1,  107, 0)); // 23
    tbl.push_back(mk(0, 0,    0, 0, 1,   -7, 0, 1, 0, 1,   -7, 0)); // 24 bypass
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,  124, 0)); // 25 history frozen
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,   19, 0)); // 26
    tbl.push_back(mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 0,   19, 0)); // 27 gap
    tbl.push_back(mk(1, 0,  511, 0, 0,    0, 0, 0, 0, 0,   19, 0)); // 28
    tbl.push_back(mk(1, 1,  511, 0, 0,    0, 0, 0, 0, 0,   19, 0)); // 29
    tbl.push_back(mk(1, 3,    0, 0, 0,    0, 0, 0, 0, 0,   19, 0)); // 30
    tbl.push_back(mk(0, 0,    0, 1, 0,    0, 1, 0, 0, 0,   19, 0)); // 31
    tbl.push_back(mk(0, 0,    0, 0, 1,  511, 0, 0, 0, 1,  510, 0)); // 32
    tbl.push_back(mk(0, 0,    0, 0, 1,  511, 0, 0, 0, 1,  511, 1)); // 33 clamp high
    tbl.push_back(mk(0, 0,    0, 0, 0,    0, 0, 0, 0, 0,  511, 1)); // 34 sticky
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1,  510, 1)); // 35 sticky
    tbl.push_back(mk(0, 0,    0, 0, 0,    0, 0, 0, 1, 0,  510, 0)); // 36 clear
    tbl.push_back(mk(0, 0,    0, 0, 0,    0, 1, 0, 0, 0,  510, 0)); // 37 flush
    tbl.push_back(mk(0, 0,    0, 0, 1, -512, 0, 0, 0, 1, -511, 0)); // 38
    tbl.push_back(mk(0, 0,    0, 0, 1, -512, 0, 0, 0, 1, -512, 1)); // 39 clamp low
    tbl.push_back(mk(0, 0,    0, 0, 1, -512, 0, 0, 1, 1, -512, 1)); // 40 set wins
    tbl.push_back(mk(0, 0,    0, 0, 0,    0, 0, 0, 1, 0, -512, 0)); // 41 clear
    tbl.push_back(mk(0, 0,    0, 0, 1,  511, 0, 1, 0, 1,  511, 0)); // 42 bypass no SAT
    tbl.push_back(mk(0, 0,    0, 0, 1,    0, 0, 0, 0, 1, -511, 0)); // 43 x1 kept -512

    #12;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("reset", r);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("row%0d", i), tbl[i]);

    // Reset mid-stream: impulse coefficients, then async reset between edges
    apply("rs_wb0", mk(1, 0, 215, 0, 0, 0, 0, 0, 0, 0, -511, 0));
    apply("rs_wb1", mk(1, 1, 215, 0, 0, 0, 0, 0, 0, 0, -511, 0));
    apply("rs_wa1", mk(1, 3, -82, 1, 0, 0, 1, 0, 0, 0, -511, 0));
    apply("rs_cm",  mk(0, 0,   0, 1, 0, 0, 1, 0, 0, 0, -511, 0));
    apply("rs_s0",  mk(0, 0,   0, 0, 1, 256, 0, 0, 0, 1, 107, 0));
    apply("rs_s1",  mk(0, 0,   0, 0, 1, 0, 0, 0, 0, 1, 124, 0));
    @(negedge clk);
    coef_commit = 1'b0; flush = 1'b0; din = '0; vin = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("rst_async", r);
    @(posedge clk);
    #1;
    check_all("rst_held", r);
    @(negedge clk);
    rst = 1'b0;
    apply("rs_nocommit", mk(0, 0, 0, 0, 1, 100, 0, 0, 0, 1, 0, 0));
    apply("rs_idle",     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_biquad_filter.md
# iir_biquad_filter

Parametrised second-order (biquad) IIR filter, Direct Form I, for the filter datapath; successor to the first-order IIR filter. Adds width/precision parameters, a second feedforward and feedback tap, double-buffered coefficient loading with atomic commit, output saturation with a sticky flag, history flush and bypass. Sits between the stimulus source and the output sink, with the same DIN/VIN to DOUT/VOUT streaming contract.

## Interface
- NB, 10, sample width (signed two's complement)
- NC, 10, coefficient width (signed)
- FRAC, 9, fractional bits of coefficients (coefficient value = code / 2^FRAC)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- DIN  in  NB  input sample, signed
- VIN  in  1  DIN valid; one sample per cycle while high, gaps allowed
- COEF_WE  in  1  write COEF_DATA into shadow register COEF_ADDR
- COEF_ADDR  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored
- COEF_DATA  in  NC  coefficient code, signed
- COEF_COMMIT  in  1  copy all shadow coefficients to the active set
- FLUSH  in  1  clear the history (x1, x2, y1, y2)
- BYPASS  in  1  DOUT follows DIN, filter state frozen
- CLR_SAT  in  1  clear SAT
- DOUT  out  NB  filtered sample, signed, registered
- VOUT  out  1  DOUT valid, registered
- SAT  out  1  sticky saturation flag

## Operation
- y[n] = sat( (b0·x[n] + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> FRAC ), using active coefficients.
- Accumulator width is NB+NC+3 bits and must not overflow. The shift is arithmetic, truncating toward −∞ with no rounding.
- sat() clamps to [−2^(NB−1), 2^(NB−1)−1]. Clamping in any accepted sample sets SAT.
- y1 stores the saturated value. The feedback path uses only the saturated output.
- When VIN=1 and BYPASS=0, on the edge:
  - x2←x1, x1←DIN, y2←y1, y1←y[n]
  - DOUT←y[n], VOUT←1
- When VIN=1 and BYPASS=1: DOUT←DIN, VOUT←1. History is held unchanged and SAT is unaffected.
- When VIN=0: VOUT←0, DOUT and history hold.
- Coefficients are double-buffered:
  - COEF_WE writes only the shadow set.
  - COEF_COMMIT copies shadow→active on the edge.
  - A sample accepted in the same cycle as COEF_COMMIT uses the old active set.
  - If COEF_WE and COEF_COMMIT are high together, the commit copies the pre-write shadow value. The write lands in shadow only.
- FLUSH clears x1, x2, y1, y2 on the edge.
  - If VIN=1 in the same cycle, that sample is computed with the old history and its output is emitted.
  - After that edge, the history is zero; the sample is not stored.
- SAT clearing: CLR_SAT clears SAT. If a saturating sample occurs in the same cycle, SAT stays 1 (set wins).

## Timing
- Latency: DOUT/VOUT register one cycle after the VIN edge. Full throughput of 1 sample/cycle.
- The feedback path completes in a single cycle, so back-to-back samples are legal.
- Reset (asynchronous, any time, including mid-stream) clears everything to 0:
  - DOUT=0, VOUT=0, SAT=0
  - history = 0
  - active and shadow coefficients = 0, so output is 0 until the first commit
- First valid output after reset release: the cycle after the first VIN=1 edge.
- BYPASS is sampled per sample. Toggling between samples resumes filtering with the history frozen at the toggle.

## Test plan
- **Pure gain.** NB=10, FRAC=9, commit b0=215, all others 0, DIN=100 with one VIN pulse → next cycle DOUT=41, VOUT=1, SAT=0.
- **Impulse response.** Commit b0=b1=215, a1=−82, b2=a2=0. Drive DIN=256 then 0,0,0,0 back-to-back → DOUT sequence 107, 124, 19, 3, 0.
- **Saturation.**
  - Commit b0=b1=511. Drive DIN=511 twice → DOUT 510 then 511 with SAT=1. SAT stays 1 until CLR_SAT.
  - Drive DIN=−512 twice → −512 on the second sample.
- **Commit atomicity.** With b0=215 active:
  - Write b0=511 (no commit), send DIN=100 → DOUT=41.
  - Pulse COEF_COMMIT in the same cycle as DIN=100 → DOUT=41.
  - Send DIN=100 on the next sample → DOUT=99.
- **Flush/bypass/gaps.**
  - Mid impulse response, pulse FLUSH → the following zero inputs give DOUT=0.
  - With BYPASS=1, DIN=−7 → DOUT=−7 and history unchanged.
  - VIN gaps → VOUT=0 and DOUT held.
- **Reset mid-stream.** Assert RST asynchronously between edges during the impulse response → DOUT=0, VOUT=0, SAT=0 immediately. After release, DIN=100 without a commit → DOUT=0.
